// File: rtl/i_fetch_q_if.sv
// Fetch-to-decode bus: redirect request from branch resolution, and the
// valid/ready instruction stream toward decode with queue occupancy.
interface i_fetch_q_if #(
   parameter int QDEPTH = 4
);
   localparam int CNT_W = $clog2(QDEPTH + 1);

   logic             redirect;
   logic [31:0]      redirect_pc;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_pc;
   logic [31:0]      out_instr;
   logic             out_err;
   logic [CNT_W-1:0] q_count;

   // fetch unit side
   modport master (
      input  redirect, redirect_pc, out_ready,
      output out_valid, out_pc, out_instr, out_err, q_count
   );

   // decode / branch-resolution side
   modport slave (
      output redirect, redirect_pc, out_ready,
      input  out_valid, out_pc, out_instr, out_err, q_count
   );
endinterface

// File: rtl/i_fetch_q.sv
// Instruction fetch unit: synchronous-read instruction memory feeding a
// circular prefetch queue, with decode back-pressure, redirect/flush and
// out-of-range fetch flagging. Issue is credit-based (queue entries plus the
// in-flight read), so a returning read always finds a free slot.
module i_fetch_q #(
   parameter int          ADDR_W   = 10,
   parameter int          QDEPTH   = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter string       MEM_INIT = ""
) (
   input  logic           clk,
   input  logic           rst,
   i_fetch_q_if.master    bus
);
   localparam int MEM_WORDS = 1 << ADDR_W;
   localparam int CNT_W     = $clog2(QDEPTH + 1);
   localparam int PTR_W     = $clog2(QDEPTH);
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // instruction memory, read-only from this block
   logic [31:0] mem [0:MEM_WORDS-1];

   // fetch / in-flight state
   logic [31:0]      fetch_pc_r;
   logic             rd_valid_r;
   logic [31:0]      rd_pc_r;
   logic [31:0]      rdata_r;

   // queue storage and bookkeeping
   logic [31:0]      q_pc_r    [0:QDEPTH-1];
   logic [31:0]      q_instr_r [0:QDEPTH-1];
   logic             q_err_r   [0:QDEPTH-1];
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [CNT_W-1:0] count_r;

   // combinational control
   logic             issue_s;
   logic             push_s;
   logic             pop_s;
   logic             oor_s;
   logic [31:0]      push_instr_s;
   logic [CNT_W:0]   credit_s;

   // credit check, push/pop qualification and out-of-range detection
   always_comb begin
      credit_s     = {1'b0, count_r} + {{CNT_W{1'b0}}, rd_valid_r};
      issue_s      = 1'b0;
      push_s       = rd_valid_r;
      pop_s        = (count_r != {CNT_W{1'b0}}) && bus.out_ready;
      oor_s        = (rd_pc_r[31:ADDR_W+2] != {(30-ADDR_W){1'b0}});
      push_instr_s = rdata_r;
      if (!rst && !bus.redirect && (credit_s < (CNT_W+1)'(QDEPTH))) begin
         issue_s = 1'b1;
      end else begin
         issue_s = 1'b0;
      end
      if (oor_s) begin
         push_instr_s = NOP_INSTR;
      end else begin
         push_instr_s = rdata_r;
      end
   end

   // synchronous memory read for the issued fetch address
   always_ff @(posedge clk) begin
      if (issue_s) begin
         rdata_r <= mem[fetch_pc_r[ADDR_W+1:2]];
      end
   end

   // fetch PC and in-flight read tracking; rst beats redirect beats issue
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_r <= RESET_PC;
         rd_valid_r <= 1'b0;
         rd_pc_r    <= 32'h0000_0000;
      end else if (bus.redirect) begin
         fetch_pc_r <= bus.redirect_pc & ~32'h0000_0003;
         rd_valid_r <= 1'b0;
         rd_pc_r    <= rd_pc_r;
      end else if (issue_s) begin
         fetch_pc_r <= fetch_pc_r + 32'd4;
         rd_valid_r <= 1'b1;
         rd_pc_r    <= fetch_pc_r;
      end else begin
         fetch_pc_r <= fetch_pc_r;
         rd_valid_r <= 1'b0;
         rd_pc_r    <= rd_pc_r;
      end
   end

   // queue pointers and occupancy; a flush clears everything, including
   // an in-flight return that would otherwise push this cycle
   always_ff @(posedge clk) begin
      if (rst || bus.redirect) begin
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // queue entry write on read return
   always_ff @(posedge clk) begin
      if (push_s && !rst && !bus.redirect) begin
         q_pc_r[wr_ptr_r]    <= rd_pc_r;
         q_instr_r[wr_ptr_r] <= push_instr_s;
         q_err_r[wr_ptr_r]   <= oor_s;
      end
   end

   // head presentation, zeroed whenever the queue is empty
   always_comb begin
      bus.out_valid = (count_r != {CNT_W{1'b0}});
      bus.q_count   = count_r;
      bus.out_pc    = 32'h0000_0000;
      bus.out_instr = 32'h0000_0000;
      bus.out_err   = 1'b0;
      if (bus.out_valid) begin
         bus.out_pc    = q_pc_r[rd_ptr_r];
         bus.out_instr = q_instr_r[rd_ptr_r];
         bus.out_err   = q_err_r[rd_ptr_r];
      end else begin
         bus.out_pc    = 32'h0000_0000;
         bus.out_instr = 32'h0000_0000;
         bus.out_err   = 1'b0;
      end
   end
endmodule
